// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the 4-core matrix-multiply processor: opcodes, sequencer
// state encoding, default widths, and an opcode classifier used by the fetch sequencer.
package proc_isa_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_INSTR_W   = 8;

  localparam logic [7:0] OP_EN0   = 8'd3;
  localparam logic [7:0] OP_EN1   = 8'd4;
  localparam logic [7:0] OP_EN2   = 8'd5;
  localparam logic [7:0] OP_EN3   = 8'd6;
  localparam logic [7:0] OP_ENALL = 8'd7;
  localparam logic [7:0] OP_MULTI = 8'd35;
  localparam logic [7:0] OP_END   = 8'd38;
  localparam logic [7:0] OP_JUMNZ = 8'd40;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    CTL_EN_ONE,
    CTL_EN_ALL,
    CTL_END,
    CTL_JUMNZ,
    CTL_DATA
  } ctl_kind_e;

  // Anything the sequencer does not consume itself is broadcast to the cores.
  function automatic ctl_kind_e classify(input logic [7:0] op);
    case (op)
      OP_EN0, OP_EN1, OP_EN2, OP_EN3: classify = CTL_EN_ONE;
      OP_ENALL:                       classify = CTL_EN_ALL;
      OP_END:                         classify = CTL_END;
      OP_JUMNZ:                       classify = CTL_JUMNZ;
      default:                        classify = CTL_DATA;
    endcase
  endfunction

endpackage

// File: rtl/core_mask_tracker.sv
// Tracks which cores are still alive and which are enabled; applies ENx/ENALL/END
// updates and produces the JUMNZ taken term from the current enable mask.
module core_mask_tracker
  import proc_isa_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int SEL_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_all_i,
  input  logic                 apply_i,
  input  ctl_kind_e            kind_i,
  input  logic [SEL_W-1:0]     en_sel_i,
  input  logic [NUM_CORES-1:0] zero_flag_i,
  output logic [NUM_CORES-1:0] core_en_o,
  output logic                 taken_o,
  output logic                 retire_all_o
);

  logic [NUM_CORES-1:0] alive_q, alive_d;
  logic [NUM_CORES-1:0] core_en_q, core_en_d;
  logic [NUM_CORES-1:0] onehot;
  logic [NUM_CORES-1:0] kill;

  assign onehot = NUM_CORES'(1) << en_sel_i;
  assign kill   = core_en_q & zero_flag_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alive_d   = alive_q;
    core_en_d = core_en_q;
    if (load_all_i) begin
      alive_d   = '1;
      core_en_d = '1;
    end else if (apply_i) begin
      case (kind_i)
        CTL_EN_ONE: core_en_d = onehot & alive_q;
        CTL_EN_ALL: core_en_d = alive_q;
        CTL_END: begin
          alive_d   = alive_q & ~kill;
          core_en_d = core_en_q & ~kill;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments with the async reset in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q   <= '0;
      core_en_q <= '0;
    end else begin
      alive_q   <= alive_d;
      core_en_q <= core_en_d;
    end
  end

  assign core_en_o    = core_en_q;
  assign taken_o      = |(core_en_q & ~zero_flag_i);
  assign retire_all_o = ~|(alive_q & ~kill);

endmodule

// File: rtl/core_fetch_sequencer.sv
// Shared fetch/issue controller: owns the PC, consumes core-control opcodes, broadcasts the
// rest with a ready handshake. Optional issue counter enabled by FETCH_PERF_CNT_EN.
module core_fetch_sequencer
  import proc_isa_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int INSTR_W   = DEF_INSTR_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0]   mem_instr,
  output logic [INSTR_W-1:0]   instr_out,
  output logic                 instr_valid,
  output logic [NUM_CORES-1:0] core_en,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] zero_flag,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          issue_count
);

  localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 jtgt_q, jtgt_d;
  logic                 taken_q, taken_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, done_q;

  logic [7:0]           op8;
  ctl_kind_e            kind;
  logic [SEL_W-1:0]     en_sel;
  logic [ADDR_W-1:0]    pc_inc;
  logic [ADDR_W-1:0]    target;
  logic                 load_all, mask_apply;
  logic [NUM_CORES-1:0] core_en_w;
  logic                 jump_taken, retire_all;
  logic                 start_ok, accept;

  assign op8      = 8'(mem_instr);
  assign kind     = classify(op8);
  assign en_sel   = SEL_W'(op8 - OP_EN0);
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign target   = ADDR_W'(mem_instr);
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept   = (state_q == ST_ISSUE) && ((core_en_w & ~core_ready) == '0);

  core_mask_tracker #(
    .NUM_CORES(NUM_CORES),
    .SEL_W    (SEL_W)
  ) u_mask (
    .clk         (clock),
    .rst_n       (reset_n),
    .load_all_i  (load_all),
    .apply_i     (mask_apply),
    .kind_i      (kind),
    .en_sel_i    (en_sel),
    .zero_flag_i (zero_flag),
    .core_en_o   (core_en_w),
    .taken_o     (jump_taken),
    .retire_all_o(retire_all)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    jtgt_d     = jtgt_q;
    taken_d    = taken_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    load_all   = 1'b0;
    mask_apply = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          jtgt_d   = 1'b0;
          taken_d  = 1'b0;
          load_all = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        if (jtgt_q) begin
          // The branch decision was frozen when JUMNZ itself was decoded.
          jtgt_d = 1'b0;
          if (taken_q) pc_d = target;
        end else begin
          mask_apply = 1'b1;
          case (kind)
            CTL_END: begin
              if (retire_all) begin
                state_d = ST_DONE;
                pc_d    = pc_q;
              end
            end
            CTL_JUMNZ: begin
              jtgt_d  = 1'b1;
              taken_d = jump_taken;
            end
            CTL_DATA: begin
              if (core_en_w != '0) begin
                instr_d = mem_instr;
                valid_d = 1'b1;
                state_d = ST_ISSUE;
                pc_d    = pc_q;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          valid_d = 1'b0;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      jtgt_q  <= 1'b0;
      taken_q <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      jtgt_q  <= jtgt_d;
      taken_q <= taken_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_ISSUE);
      done_q  <= (state_d == ST_DONE);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] issue_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt_q <= '0;
    end else if (start_ok) begin
      issue_cnt_q <= '0;
    end else if (accept && (issue_cnt_q != 16'hFFFF)) begin
      issue_cnt_q <= issue_cnt_q + 16'd1;
    end
  end

  assign issue_count = issue_cnt_q;
`else
  assign issue_count = 16'h0000;
`endif

  assign mem_addr    = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign core_en     = core_en_w;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_core_fetch_sequencer.sv
// Directed bench for core_fetch_sequencer with a synchronous-read instruction memory model.
module tb_core_fetch_sequencer;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_instr;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic [3:0] core_en;
  logic [3:0] core_ready;
  logic [3:0] zero_flag;
  logic       busy;
  logic       done;
  logic [15:0] issue_count;

  logic [7:0] mem [0:255];
  int checks;
  int errors;

  core_fetch_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_instr  (mem_instr),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .core_en    (core_en),
    .core_ready (core_ready),
    .zero_flag  (zero_flag),
    .busy       (busy),
    .done       (done),
    .issue_count(issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) mem_instr <= mem[mem_addr];

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd38;
  endtask

  task automatic start_run();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; core_ready = 4'b1111; zero_flag = 4'b0000;
    clear_mem();
    #3;
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL rst_addr got %h exp %h", mem_addr, 8'd0); end
    checks++; if (instr_out !== 8'd0) begin errors++; $display("FAIL rst_instr got %h exp %h", instr_out, 8'd0); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    checks++; if (core_en !== 4'b0000) begin errors++; $display("FAIL rst_core_en got %b exp 0000", core_en); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b exp 00", {busy, done}); end
    checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL rst_count got %h exp 0", issue_count); end
    tick(2);
    reset_n = 1'b1;
    tick(3);
    checks++; if ({busy, done, mem_addr} !== 10'd0) begin errors++; $display("FAIL idle_hold got %b/%b/%h exp 0/0/00", busy, done, mem_addr); end
  endtask

  task automatic test_issue_end();
    clear_mem();
    mem[0] = 8'd7; mem[1] = 8'd35; mem[2] = 8'd38; mem[3] = 8'd7; mem[4] = 8'd38;
    zero_flag = 4'b0101; core_ready = 4'b1111;
    start_run();
    checks++; if ({busy, core_en, mem_addr} !== {1'b1, 4'b1111, 8'd0}) begin errors++; $display("FAIL t1_start got %b/%b/%h exp 1/1111/00", busy, core_en, mem_addr); end
    checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL t1_cnt0 got %h exp 0", issue_count); end
    tick(4);
    checks++; if ({instr_valid, instr_out, core_en} !== {1'b1, 8'd35, 4'b1111}) begin errors++; $display("FAIL t1_issue got %b/%h/%b exp 1/23/1111", instr_valid, instr_out, core_en); end
    tick(1);
    checks++; if ({instr_valid, mem_addr} !== {1'b0, 8'd2}) begin errors++; $display("FAIL t1_accept got %b/%h exp 0/02", instr_valid, mem_addr); end
    checks++; if (issue_count !== (PERF ? 16'd1 : 16'd0)) begin errors++; $display("FAIL t1_cnt1 got %h exp %h", issue_count, (PERF ? 16'd1 : 16'd0)); end
    tick(2);
    checks++; if ({core_en, mem_addr, done} !== {4'b1010, 8'd3, 1'b0}) begin errors++; $display("FAIL t1_end got %b/%h/%b exp 1010/03/0", core_en, mem_addr, done); end
    tick(2);
    checks++; if (core_en !== 4'b1010) begin errors++; $display("FAIL t1_alive got %b exp 1010", core_en); end
    zero_flag = 4'b1111;
    tick(2);
    checks++; if ({done, busy, core_en, mem_addr} !== {1'b1, 1'b0, 4'b0000, 8'd4}) begin errors++; $display("FAIL t1_done got %b/%b/%b/%h exp 1/0/0000/04", done, busy, core_en, mem_addr); end
  endtask

  task automatic test_backpressure();
    clear_mem();
    mem[0] = 8'd7; mem[1] = 8'd35; mem[2] = 8'd38;
    zero_flag = 4'b0000; core_ready = 4'b1110;
    start_run();
    checks++; if ({done, busy, issue_count} !== {1'b0, 1'b1, 16'd0}) begin errors++; $display("FAIL t2_restart got %b/%b/%h exp 0/1/0000", done, busy, issue_count); end
    tick(4);
    checks++; if ({instr_valid, mem_addr} !== {1'b1, 8'd1}) begin errors++; $display("FAIL t2_v1 got %b/%h exp 1/01", instr_valid, mem_addr); end
    tick(1);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL t2_v2 got %b exp 1", instr_valid); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if ({instr_valid, instr_out, mem_addr, core_en} !== {1'b1, 8'd35, 8'd1, 4'b1111}) begin errors++; $display("FAIL t2_v3 got %b/%h/%h/%b exp 1/23/01/1111", instr_valid, instr_out, mem_addr, core_en); end
    core_ready = 4'b1111;
    tick(1);
    checks++; if ({instr_valid, mem_addr} !== {1'b0, 8'd2}) begin errors++; $display("FAIL t2_acc got %b/%h exp 0/02", instr_valid, mem_addr); end
    zero_flag = 4'b1111;
    tick(2);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done got %b exp 1", done); end
  endtask

  task automatic test_jumnz();
    clear_mem();
    mem[0] = 8'd40; mem[1] = 8'd60; mem[60] = 8'd40; mem[61] = 8'd28;
    mem[28] = 8'd40; mem[29] = 8'd60; mem[62] = 8'd38;
    zero_flag = 4'b0000; core_ready = 4'b1111;
    start_run();
    tick(4);
    checks++; if (mem_addr !== 8'd60) begin errors++; $display("FAIL t3_j1 got %h exp 3c", mem_addr); end
    tick(4);
    checks++; if (mem_addr !== 8'd28) begin errors++; $display("FAIL t3_taken got %h exp 1c", mem_addr); end
    tick(4);
    checks++; if (mem_addr !== 8'd60) begin errors++; $display("FAIL t3_j3 got %h exp 3c", mem_addr); end
    zero_flag = 4'b1111;
    tick(2);
    checks++; if (mem_addr !== 8'd61) begin errors++; $display("FAIL t3_tgtfetch got %h exp 3d", mem_addr); end
    tick(2);
    checks++; if ({mem_addr, instr_valid} !== {8'd62, 1'b0}) begin errors++; $display("FAIL t3_not_taken got %h/%b exp 3e/0", mem_addr, instr_valid); end
    tick(2);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3_done got %b exp 1", done); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 8'd40; mem[1] = 8'd255; mem[255] = 8'd40; mem[40] = 8'd38; mem[41] = 8'd38;
    zero_flag = 4'b0000; core_ready = 4'b1111;
    start_run();
    tick(4);
    checks++; if (mem_addr !== 8'd255) begin errors++; $display("FAIL t4_to255 got %h exp ff", mem_addr); end
    tick(2);
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL t4_wrap got %h exp 00", mem_addr); end
    tick(2);
    checks++; if (mem_addr !== 8'd40) begin errors++; $display("FAIL t4_target got %h exp 28", mem_addr); end
    tick(2);
    checks++; if ({core_en, mem_addr, busy} !== {4'b1111, 8'd41, 1'b1}) begin errors++; $display("FAIL t4_end_noop got %b/%h/%b exp 1111/29/1", core_en, mem_addr, busy); end
    zero_flag = 4'b1111;
    tick(2);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t4_done got %b exp 1", done); end
  endtask

  task automatic test_retired_enable();
    clear_mem();
    mem[0] = 8'd38; mem[1] = 8'd5; mem[2] = 8'd20; mem[3] = 8'd38; mem[4] = 8'd7; mem[5] = 8'd38;
    zero_flag = 4'b0100; core_ready = 4'b1111;
    start_run();
    tick(2);
    checks++; if ({core_en, mem_addr} !== {4'b1011, 8'd1}) begin errors++; $display("FAIL t5_retire2 got %b/%h exp 1011/01", core_en, mem_addr); end
    tick(2);
    checks++; if (core_en !== 4'b0000) begin errors++; $display("FAIL t5_en2 got %b exp 0000", core_en); end
    tick(2);
    checks++; if ({instr_valid, mem_addr} !== {1'b0, 8'd3}) begin errors++; $display("FAIL t5_skip got %b/%h exp 0/03", instr_valid, mem_addr); end
    tick(2);
    checks++; if ({core_en, mem_addr, busy} !== {4'b0000, 8'd4, 1'b1}) begin errors++; $display("FAIL t5_end_en0 got %b/%h/%b exp 0000/04/1", core_en, mem_addr, busy); end
    tick(2);
    checks++; if (core_en !== 4'b1011) begin errors++; $display("FAIL t5_enall got %b exp 1011", core_en); end
    zero_flag = 4'b1011;
    tick(2);
    checks++; if ({done, busy, core_en} !== {1'b1, 1'b0, 4'b0000}) begin errors++; $display("FAIL t5_done got %b/%b/%b exp 1/0/0000", done, busy, core_en); end
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = 8'd35; mem[1] = 8'd35; mem[2] = 8'd35;
    zero_flag = 4'b0000; core_ready = 4'b1111;
    start_run();
    tick(6);
    checks++; if (issue_count !== (PERF ? 16'd2 : 16'd0)) begin errors++; $display("FAIL t6_cnt2 got %h exp %h", issue_count, (PERF ? 16'd2 : 16'd0)); end
    core_ready = 4'b0000;
    tick(3);
    checks++; if ({instr_valid, mem_addr} !== {1'b1, 8'd2}) begin errors++; $display("FAIL t6_hold got %b/%h exp 1/02", instr_valid, mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({instr_valid, core_en, busy} !== 6'd0) begin errors++; $display("FAIL t6_async got %b/%b/%b exp 0/0000/0", instr_valid, core_en, busy); end
    checks++; if ({issue_count, mem_addr} !== 24'd0) begin errors++; $display("FAIL t6_async_cnt got %h/%h exp 0000/00", issue_count, mem_addr); end
    @(negedge clock);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_issue_end();
    test_backpressure();
    test_jumnz();
    test_wrap();
    test_retired_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
